spike_address_dispatcher: RTL and testbench

//  Upstream feeder for the macNN synapse units. Buffers incoming spike source addresses in a FIFO and

---
 rtl/spike_address_dispatcher.sv | 194 +++++++++++++++++++
 tb/tb_spike_address_dispatcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_address_dispatcher.sv
// Spike source-address dispatcher: FIFO-buffers spike addresses and replays them onto the
// shared MAC source_address bus, sequencing set_mac init and clear_mac end-of-timestep pulses.
module spike_address_dispatcher #(
  parameter int              ADDR_W       = 12,
  parameter int              FIFO_DEPTH   = 16,
  parameter int              HOLD_CYCLES  = 2,
  parameter int              CLEAR_CYCLES = 2,
  parameter int              SET_CYCLES   = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = {ADDR_W{1'b1}}
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic                            spike_valid,
  input  logic [ADDR_W-1:0]               spike_addr,
  output logic                            spike_ready,
  input  logic                            timestep_end,
  input  logic                            init_req,
  output logic [ADDR_W-1:0]               source_address,
  output logic                            set_mac,
  output logic                            clear_mac,
  output logic                            timestep_done,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            ts_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = 8;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_DRIVE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, drain_q, drain_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] bus_q, bus_d;
  logic              set_q, set_d, clr_q, clr_d, done_q, done_d;
  logic              ovr_q, ovr_d, ready_q, ready_d;
  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];

  logic              abort, push, pop;
  logic [ADDR_W-1:0] head;

  always_comb begin
    abort = init_req && (state_q != S_INIT);
    push  = spike_valid && ready_q && !abort && (state_q != S_INIT);
    pop   = (state_q == S_DRIVE) && (tmr_q == TMR_W'(HOLD_CYCLES - 1)) && !abort;
    head  = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pending_d = pending_q;
    drain_d   = drain_q;
    ovr_d     = ovr_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_INIT: begin
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        count_d   = '0;
        pending_d = 1'b0;
        drain_d   = '0;
        if (tmr_q == TMR_W'(SET_CYCLES - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      // GAP shares the idle decision so back-to-back addresses need no extra idle cycle.
      // A closed timestep is cleared before any later spike is driven.
      S_IDLE, S_GAP: begin
        tmr_d = '0;
        if (pending_q && drain_q == '0) begin
          state_d = S_CLEAR;
        end else if (count_q != '0) begin
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
          state_d = S_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (tmr_q == TMR_W'(CLEAR_CYCLES - 1)) begin
          state_d = S_DONE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DONE: begin
        pending_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        tmr_d   = '0;
      end
    endcase

    // Snapshot excludes a same-cycle push (next timestep) and a same-cycle pop (already gone).
    if (timestep_end && state_q != S_INIT && !abort) begin
      if (pending_q) begin
        ovr_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        drain_d   = count_q - CNT_W'(pop);
      end
    end else if (pending_q && pop && drain_q != '0) begin
      drain_d = drain_q - 1'b1;
    end

    if (abort) begin
      state_d   = S_INIT;
      tmr_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pending_d = 1'b0;
      drain_d   = '0;
    end

    bus_d   = (state_q == S_DRIVE && !abort) ? head : IDLE_ADDR;
    set_d   = (state_q == S_INIT);
    clr_d   = (state_q == S_CLEAR) && !abort;
    done_d  = (state_q == S_DONE) && !abort;
    ready_d = (state_d != S_INIT) && (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= spike_addr;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      tmr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drain_q   <= '0;
      pending_q <= 1'b0;
      bus_q     <= IDLE_ADDR;
      set_q     <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
      bus_q     <= bus_d;
      set_q     <= set_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      ready_q   <= ready_d;
    end
  end

  assign source_address = bus_q;
  assign set_mac        = set_q;
  assign clear_mac      = clr_q;
  assign timestep_done  = done_q;
  assign fifo_count     = count_q;
  assign ts_overrun     = ovr_q;
  assign spike_ready    = ready_q;

endmodule

// File: tb/tb_spike_address_dispatcher.sv
// Directed bench for spike_address_dispatcher: table-driven bus/clear/done vectors plus
// hand-written sequences for reset, FIFO full, overrun, init abort and async reset.
module tb_spike_address_dispatcher;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        spike_valid = 1'b0;
  logic [11:0] spike_addr = '0;
  logic        spike_ready;
  logic        timestep_end = 1'b0;
  logic        init_req = 1'b0;
  logic [11:0] source_address;
  logic        set_mac, clear_mac, timestep_done, ts_overrun;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  spike_address_dispatcher dut (
    .CLK(CLK), .reset(reset),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_ready(spike_ready),
    .timestep_end(timestep_end), .init_req(init_req),
    .source_address(source_address), .set_mac(set_mac), .clear_mac(clear_mac),
    .timestep_done(timestep_done), .fifo_count(fifo_count), .ts_overrun(ts_overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [11:0] a;
    logic        te;
    logic [11:0] bus;
    logic        clr;
    logic        done;
    logic [4:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [11:0] a, input logic te,
                     input logic [11:0] bus, input logic clr, input logic done,
                     input logic [4:0] cnt);
    vec_t r;
    r.v = v; r.a = a; r.te = te; r.bus = bus; r.clr = clr; r.done = done; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and leave time to sample settled outputs.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [11:0] acc_q[$];
  logic [11:0] seen_q[$];
  logic [11:0] prev_bus;

  task automatic observe();
    if (source_address != 12'hFFF && prev_bus == 12'hFFF) seen_q.push_back(source_address);
    prev_bus = source_address;
    chk("count_le_depth", 32'(fifo_count <= 5'd16), 32'd1);
    if (fifo_count == 5'd16) chk("full_ready_low", 32'(spike_ready), 32'd0);
  endtask

  initial begin
    int nxt;
    bit hit16;
    bit acc;
    bit drained;
    bit found;

    // 8,9,10,10 back to back
    add(1, 12'd8, 0, 12'hFFF, 0, 0, 1);
    add(1, 12'd9, 0, 12'hFFF, 0, 0, 2);
    add(1, 12'd10, 0, 12'd8, 0, 0, 3);
    add(1, 12'd10, 0, 12'd8, 0, 0, 3);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 3);
    add(0, 12'd0, 0, 12'd9, 0, 0, 3);
    add(0, 12'd0, 0, 12'd9, 0, 0, 2);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 2);
    add(0, 12'd0, 0, 12'd10, 0, 0, 2);
    add(0, 12'd0, 0, 12'd10, 0, 0, 1);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 1);
    add(0, 12'd0, 0, 12'd10, 0, 0, 1);
    add(0, 12'd0, 0, 12'd10, 0, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 0);
    // 11 then timestep_end
    add(1, 12'd11, 0, 12'hFFF, 0, 0, 1);
    add(0, 12'd0, 1, 12'hFFF, 0, 0, 1);
    add(0, 12'd0, 0, 12'd11, 0, 0, 1);
    add(0, 12'd0, 0, 12'd11, 0, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 1, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 1, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 0, 1, 0);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 0);
    // 12 in the same cycle as timestep_end: clear first
    add(1, 12'd12, 1, 12'hFFF, 0, 0, 1);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 1);
    add(0, 12'd0, 0, 12'hFFF, 1, 0, 1);
    add(0, 12'd0, 0, 12'hFFF, 1, 0, 1);
    add(0, 12'd0, 0, 12'hFFF, 0, 1, 1);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 1);
    add(0, 12'd0, 0, 12'd12, 0, 0, 1);
    add(0, 12'd0, 0, 12'd12, 0, 0, 0);
    add(0, 12'd0, 0, 12'hFFF, 0, 0, 0);

    // Reset values, asynchronously visible
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_bus", 32'(source_address), 32'hFFF);
    chk("rst_set", 32'(set_mac), 32'd0);
    chk("rst_ready", 32'(spike_ready), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;

    // timestep_end during INIT must be ignored without overrun
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    chk("init_set_c1", 32'(set_mac), 32'd1);
    chk("init_ready_c1", 32'(spike_ready), 32'd0);
    tick();
    chk("init_set_c2", 32'(set_mac), 32'd1);
    tick();
    chk("init_set_c3", 32'(set_mac), 32'd0);
    chk("init_ready_c3", 32'(spike_ready), 32'd1);
    chk("init_bus_c3", 32'(source_address), 32'hFFF);
    chk("init_no_overrun", 32'(ts_overrun), 32'd0);
    tick();
    chk("init_no_clear", 32'(clear_mac), 32'd0);
    $display("reset/init sequence done");

    foreach (tbl[i]) begin
      spike_valid  = tbl[i].v;
      spike_addr   = tbl[i].a;
      timestep_end = tbl[i].te;
      tick();
      spike_valid  = 1'b0;
      timestep_end = 1'b0;
      $display("vec %0d: v=%0d a=%0h te=%0d -> bus=%0h clr=%0d done=%0d cnt=%0d",
               i, tbl[i].v, tbl[i].a, tbl[i].te, source_address, clear_mac, timestep_done, fifo_count);
      chk($sformatf("vec%0d_bus", i), 32'(source_address), 32'(tbl[i].bus));
      chk($sformatf("vec%0d_clr", i), 32'(clear_mac), 32'(tbl[i].clr));
      chk($sformatf("vec%0d_done", i), 32'(timestep_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_ready", i), 32'(spike_ready), 32'd1);
      chk($sformatf("vec%0d_ovr", i), 32'(ts_overrun), 32'd0);
    end

    // Fill the FIFO with continuous pushes; order must be preserved
    nxt = 0;
    hit16 = 0;
    prev_bus = source_address;
    for (int i = 0; i < 40; i++) begin
      spike_valid = 1'b1;
      spike_addr  = 12'h100 + 12'(nxt);
      acc = spike_ready;
      tick();
      if (acc) begin
        acc_q.push_back(spike_addr);
        nxt++;
      end
      if (fifo_count == 5'd16) hit16 = 1;
      observe();
    end
    spike_valid = 1'b0;
    drained = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      observe();
      if (fifo_count == 5'd0 && source_address == 12'hFFF) begin
        drained = 1;
        break;
      end
    end
    $display("fill: accepted %0d, driven %0d", acc_q.size(), seen_q.size());
    chk("fill_drained", 32'(drained), 32'd1);
    chk("fill_hit16", 32'(hit16), 32'd1);
    chk("fill_order_size", 32'(seen_q.size()), 32'(acc_q.size()));
    for (int i = 0; i < acc_q.size() && i < seen_q.size(); i++)
      chk($sformatf("fill_order%0d", i), 32'(seen_q[i]), 32'(acc_q[i]));

    // Second timestep_end while pending sets sticky overrun
    spike_valid = 1'b1; spike_addr = 12'd1; tick();
    spike_addr = 12'd2; tick();
    spike_valid = 1'b0;
    timestep_end = 1'b1; tick();
    chk("ovr_after_first_te", 32'(ts_overrun), 32'd0);
    tick();
    timestep_end = 1'b0;
    $display("overrun: ovr=%0d", ts_overrun);
    chk("ovr_after_second_te", 32'(ts_overrun), 32'd1);

    // init_req while an address is on the bus
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (source_address != 12'hFFF) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("drive_seen", 32'(found), 32'd1);
    init_req = 1'b1; tick(); init_req = 1'b0;
    chk("abort_bus", 32'(source_address), 32'hFFF);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_ready", 32'(spike_ready), 32'd0);
    tick();
    chk("abort_set1", 32'(set_mac), 32'd1);
    tick();
    chk("abort_set2", 32'(set_mac), 32'd1);
    tick();
    chk("abort_set_off", 32'(set_mac), 32'd0);
    chk("abort_ready_back", 32'(spike_ready), 32'd1);
    chk("abort_ovr_sticky", 32'(ts_overrun), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_clear", 32'(clear_mac), 32'd0);
      chk("abort_bus_idle", 32'(source_address), 32'hFFF);
    end
    $display("init abort: count=%0d bus=%0h", fifo_count, source_address);

    // Asynchronous reset mid-operation
    spike_valid = 1'b1; spike_addr = 12'd3; tick();
    spike_valid = 1'b0;
    chk("pre_async_count", 32'(fifo_count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_count", 32'(fifo_count), 32'd0);
    chk("async_ovr", 32'(ts_overrun), 32'd0);
    chk("async_ready", 32'(spike_ready), 32'd0);
    chk("async_bus", 32'(source_address), 32'hFFF);
    $display("async reset: count=%0d ovr=%0d", fifo_count, ts_overrun);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
